// File: rtl/dbuf_pingpong_ctrl.sv
// Ping-pong double-buffer controller over a 1R1W RAM split into two banks on the address MSB.
// Optional macro DBUF_TRUNC_FLAG_EN adds m_trunc_o and the sticky trunc_err_o outputs.
module dbuf_pingpong_ctrl #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10,
  parameter int EN_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [EN_W-1:0]   s_be_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              ram_en_a_o,
  output logic [EN_W-1:0]   ram_wren_a_o,
  output logic [ADDR_W-1:0] ram_wraddr_a_o,
  output logic [DATA_W-1:0] ram_wrdata_a_o,
  output logic              ram_rden_b_o,
  output logic [ADDR_W-1:0] ram_rdaddr_b_o,
  input  logic [DATA_W-1:0] ram_rddata_i
`ifdef DBUF_TRUNC_FLAG_EN
  ,
  output logic              m_trunc_o,
  output logic              trunc_err_o
`endif
);

  localparam int               CNT_W   = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {FREE, COMMIT, READY, DRAIN} bank_st_e;

  bank_st_e          st_q [2];
  bank_st_e          st_d [2];
  logic              cmt_q [2];
  logic              cmt_d [2];

  logic              wr_bank_q, rd_bank_q;
  logic [CNT_W-1:0]  wcnt_q, rcnt_q;
  logic [CNT_W-1:0]  last_idx_q [2];

  logic              wr_acc, wr_end, rd_can, rd_issue, rd_end, pop, pop_last;
  logic [2:0]        occ_w;

  logic              rd_vld_p1, rd_last_p1, rd_bank_p1;

  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              fifo_bank [2];
  logic              fifo_wp_q, fifo_rp_q;
  logic [1:0]        fifo_cnt_q;

  // Bank FSMs: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= FREE;
        cmt_q[b] <= 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= st_d[b];
        cmt_q[b] <= cmt_d[b];
      end
    end
  end

  // Bank FSMs: next state; COMMIT lasts two cycles to cover the RAM's registered write
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b]  = st_q[b];
      cmt_d[b] = cmt_q[b];
      case (st_q[b])
        FREE:    if (wr_end && wr_bank_q == 1'(b)) begin
                   st_d[b]  = COMMIT;
                   cmt_d[b] = 1'b0;
                 end
        COMMIT:  if (cmt_q[b]) st_d[b] = READY;
                 else          cmt_d[b] = 1'b1;
        READY:   if (rd_issue && rd_bank_q == 1'(b)) st_d[b] = DRAIN;
        DRAIN:   if (pop_last && fifo_bank[fifo_rp_q] == 1'(b)) st_d[b] = FREE;
        default: st_d[b] = FREE;
      endcase
    end
  end

  // Bank FSMs: outputs. A DRAIN bank with rcnt==0 has all reads issued and only waits for its last pop.
  always_comb begin
    s_ready_o = (st_q[wr_bank_q] == FREE);
    rd_can    = (st_q[rd_bank_q] == READY) ||
                (st_q[rd_bank_q] == DRAIN && rcnt_q != '0);
  end

  assign wr_acc         = s_valid_i && s_ready_o;
  assign wr_end         = wr_acc && (s_last_i || wcnt_q == CNT_MAX);
  assign ram_en_a_o     = wr_acc;
  assign ram_wren_a_o   = wr_acc ? s_be_i : '0;
  assign ram_wraddr_a_o = {wr_bank_q, wcnt_q};
  assign ram_wrdata_a_o = s_data_i;

  assign m_valid_o = (fifo_cnt_q != 2'd0);
  assign pop       = m_valid_o && m_ready_i;
  assign pop_last  = pop && fifo_last[fifo_rp_q];
  assign m_data_o  = m_valid_o ? fifo_data[fifo_rp_q] : '0;
  assign m_last_o  = m_valid_o && fifo_last[fifo_rp_q];

  // A slot freed by this cycle's pop can be refilled by a read issued this cycle
  assign occ_w          = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign rd_issue       = rd_can && (occ_w < 3'd2);
  assign rd_end         = rd_issue && (rcnt_q == last_idx_q[rd_bank_q]);
  assign ram_rden_b_o   = rd_issue;
  assign ram_rdaddr_b_o = {rd_bank_q, rcnt_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wcnt_q    <= '0;
    end else if (wr_acc) begin
      if (wr_end) begin
        wr_bank_q <= ~wr_bank_q;
        wcnt_q    <= '0;
      end else begin
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_end) last_idx_q[wr_bank_q] <= wcnt_q;
  end

  // Read stage p0 -> p1: address issued, RAM data returns next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q <= 1'b0;
      rcnt_q    <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_issue;
      if (rd_issue) begin
        if (rd_end) begin
          rd_bank_q <= ~rd_bank_q;
          rcnt_q    <= '0;
        end else begin
          rcnt_q <= rcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_last_p1 <= rd_end;
    rd_bank_p1 <= rd_bank_q;
  end

  // Read stage p1 -> skid FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (rd_vld_p1) fifo_wp_q <= ~fifo_wp_q;
      if (pop)       fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1) begin
      fifo_data[fifo_wp_q] <= ram_rddata_i;
      fifo_last[fifo_wp_q] <= rd_last_p1;
      fifo_bank[fifo_wp_q] <= rd_bank_p1;
    end
  end

`ifdef DBUF_TRUNC_FLAG_EN
  logic trunc_q [2];
  logic rd_trunc_p1;
  logic fifo_trunc [2];
  logic trunc_err_q;

  always_ff @(posedge clk) begin
    if (wr_end) trunc_q[wr_bank_q] <= ~s_last_i;
    rd_trunc_p1 <= trunc_q[rd_bank_q];
    if (rd_vld_p1) fifo_trunc[fifo_wp_q] <= rd_trunc_p1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                    trunc_err_q <= 1'b0;
    else if (wr_end && !s_last_i)  trunc_err_q <= 1'b1;
  end

  assign m_trunc_o   = m_last_o && fifo_trunc[fifo_rp_q];
  assign trunc_err_o = trunc_err_q;
`endif

endmodule
